rename_map_table: RTL



---
 rtl/rename_map_table_if.sv | 60 ++++++
 rtl/rename_map_table.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rename_map_table_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rename_map_table_if                                                  |
// | Decode, free-list, downstream and squash signals of the rename stage |
// | Optional macro: RENAME_COMMIT_RAT_EN (commit / recover signals)      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rename_map_table_if #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [AREG_W-1:0] in_rs1;
  logic [AREG_W-1:0] in_rs2;
  logic [AREG_W-1:0] in_rd;
  logic              in_rd_we;
  logic              alloc_req;
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_preg;
  logic              out_valid;
  logic              out_ready;
  logic [PREG_W-1:0] out_prs1;
  logic [PREG_W-1:0] out_prs2;
  logic [PREG_W-1:0] out_prd;
  logic [PREG_W-1:0] out_old_prd;
  logic              out_rd_we;
  logic              flush;
  logic              reclaim_valid;
  logic [PREG_W-1:0] reclaim_preg;
  logic [7:0]        stall_cnt;
`ifdef RENAME_COMMIT_RAT_EN
  logic              commit_valid;
  logic [AREG_W-1:0] commit_rd;
  logic [PREG_W-1:0] commit_prd;
  logic              recover;
`endif

  // Rename block side
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    input  alloc_valid, alloc_preg, out_ready, flush,
    output in_ready, alloc_req, out_valid, out_prs1, out_prs2, out_prd,
    output out_old_prd, out_rd_we, reclaim_valid, reclaim_preg, stall_cnt
`ifdef RENAME_COMMIT_RAT_EN
    , input commit_valid, commit_rd, commit_prd, recover
`endif
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
    output alloc_valid, alloc_preg, out_ready, flush,
    input  in_ready, alloc_req, out_valid, out_prs1, out_prs2, out_prd,
    input  out_old_prd, out_rd_we, reclaim_valid, reclaim_preg, stall_cnt
`ifdef RENAME_COMMIT_RAT_EN
    , output commit_valid, commit_rd, commit_prd, recover
`endif
  );
endinterface
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rename_map_table                                                     |
// | Speculative register alias table with a one-deep rename sequencer.   |
// | Optional macro: RENAME_COMMIT_RAT_EN (committed map and recover)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rename_map_table #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  rename_map_table_if.slave rn_if
);
  localparam int NREG = 1 << AREG_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALLOC = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]                   state_q, state_d;
  logic [NREG-1:0][PREG_W-1:0]  w_map;
  logic [AREG_W-1:0]            rd_q;
  logic [PREG_W-1:0]            prs1_q, prs2_q, prd_q, old_prd_q, reclaim_preg_q;
  logic                         rd_we_q, reclaim_valid_q;
  logic [7:0]                   stall_q;
  logic                         w_flush, w_accept, w_map_we, w_rc_valid;
  logic [PREG_W-1:0]            w_map_wdata, w_rc_preg;

`ifdef RENAME_COMMIT_RAT_EN
  logic [NREG-1:0][PREG_W-1:0]  w_cmt;

  // Recover squashes the in-flight instruction exactly like a flush
  assign w_flush = rn_if.flush | rn_if.recover;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cmt
    if (gi == 0) begin : g_zero
      assign w_cmt[gi] = '0;
    end else begin : g_entry
      logic [PREG_W-1:0] ent_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          ent_q <= '0;
        else if (rn_if.commit_valid && rn_if.commit_rd == AREG_W'(gi))
          ent_q <= rn_if.commit_prd;
      end
      assign w_cmt[gi] = ent_q;
    end
  end
`else
  assign w_flush = rn_if.flush;
`endif

  assign w_accept = (state_q == S_IDLE) && rn_if.in_valid;

  // One write port: the grant in WAIT, or the undo of a squashed rename in OUT
  assign w_map_we    = ((state_q == S_WAIT) && !w_flush && rn_if.alloc_valid) ||
                       ((state_q == S_OUT) && w_flush && rd_we_q);
  assign w_map_wdata = (state_q == S_OUT) ? old_prd_q : rn_if.alloc_preg;

  assign w_rc_valid  = (((state_q == S_DRAIN) || ((state_q == S_WAIT) && w_flush)) &&
                        rn_if.alloc_valid) ||
                       ((state_q == S_OUT) && w_flush && rd_we_q);
  assign w_rc_preg   = (state_q == S_OUT) ? prd_q : rn_if.alloc_preg;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_map
    if (gi == 0) begin : g_zero
      assign w_map[gi] = '0;
    end else begin : g_entry
      logic [PREG_W-1:0] ent_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          ent_q <= '0;
`ifdef RENAME_COMMIT_RAT_EN
        else if (rn_if.recover)
          ent_q <= w_cmt[gi];
`endif
        else if (w_map_we && rd_q == AREG_W'(gi))
          ent_q <= w_map_wdata;
      end
      assign w_map[gi] = ent_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rn_if.in_valid)
                 state_d = (rn_if.in_rd_we && rn_if.in_rd != '0) ? S_ALLOC : S_OUT;
      S_ALLOC: state_d = w_flush ? S_DRAIN : S_WAIT;
      S_WAIT:  if (w_flush)                state_d = S_IDLE;
               else if (rn_if.alloc_valid) state_d = S_OUT;
               else                        state_d = S_ALLOC;
      S_OUT:   if (w_flush || rn_if.out_ready) state_d = S_IDLE;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rn_if.in_ready  = 1'b0;
    rn_if.alloc_req = 1'b0;
    rn_if.out_valid = 1'b0;
    case (state_q)
      S_IDLE:  rn_if.in_ready  = 1'b1;
      S_ALLOC: rn_if.alloc_req = !w_flush;
      S_OUT:   rn_if.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q            <= '0;
      prs1_q          <= '0;
      prs2_q          <= '0;
      prd_q           <= '0;
      old_prd_q       <= '0;
      rd_we_q         <= 1'b0;
      stall_q         <= '0;
      reclaim_valid_q <= 1'b0;
      reclaim_preg_q  <= '0;
    end else begin
      reclaim_valid_q <= w_rc_valid;
      reclaim_preg_q  <= w_rc_valid ? w_rc_preg : '0;
      if (w_accept) begin
        rd_q      <= rn_if.in_rd;
        prs1_q    <= w_map[rn_if.in_rs1];
        prs2_q    <= w_map[rn_if.in_rs2];
        old_prd_q <= w_map[rn_if.in_rd];
        prd_q     <= '0;
        rd_we_q   <= 1'b0;
        stall_q   <= '0;
      end else if (state_q == S_WAIT && !w_flush) begin
        if (rn_if.alloc_valid) begin
          prd_q   <= rn_if.alloc_preg;
          rd_we_q <= 1'b1;
        end else if (stall_q != 8'hFF) begin
          stall_q <= stall_q + 8'd1;
        end
      end
    end
  end

  assign rn_if.out_prs1      = prs1_q;
  assign rn_if.out_prs2      = prs2_q;
  assign rn_if.out_prd       = prd_q;
  assign rn_if.out_old_prd   = old_prd_q;
  assign rn_if.out_rd_we     = rd_we_q;
  assign rn_if.reclaim_valid = reclaim_valid_q;
  assign rn_if.reclaim_preg  = reclaim_preg_q;
  assign rn_if.stall_cnt     = stall_q;
endmodule
`default_nettype wire
